adder_substractor_serial_nbit: RTL and testbench
================================================

# adder_substractor_serial_nbit

Bit-serial, clocked counterpart of the combinational n-bit adder/subtractor. It accepts one operation per request, computes x + y or x − y over n cycles (LSB first), and returns s and cout with a one-cycle done pulse. It is intended for area-constrained datapaths and shares the add_n and cout conventions of the combinational adder/subtractor, so results from the two blocks compare directly.

## Interface
- n, default 8: operand and result width in bits; legal range is n ≥ 2.

- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: asynchronous reset, active-high.
- start, input, 1: request; sampled only in IDLE.
- x, input, n: operand A; sampled on the accepting edge.
- y, input, n: operand B; sampled on the accepting edge.
- add_n, input, 1: 0 selects add, 1 selects subtract (x − y). Sampled on the accepting edge.
- busy, output, 1: high in RUN and DONE.
- done, output, 1: one-cycle pulse; s and cout are valid.
- s, output, n: result register.
- cout, output, 1: carry out. For subtract, 1 means no borrow (x ≥ y unsigned).

## Operation
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1. Exactly n bit-steps.
  - DONE: busy=1, done=1 for one cycle.
- IDLE→RUN on an edge with start=1. On that edge:
  - opa ← x.
  - opb ← y XOR {n{add_n}}.
  - carry ← add_n (two's-complement subtract).
  - acc ← 0.
  - bit counter ← 0.
- RUN, each edge:
  - sum = opa[0] ^ opb[0] ^ carry.
  - carry ← majority(opa[0], opb[0], carry).
  - opa and opb shift right one bit.
  - acc shifts right with sum entering at bit n−1.
  - counter increments.
- RUN→DONE on the edge where the counter reaches n−1, i.e. the n-th bit-step. On that same edge, s ← final acc value (including that step's sum bit) and cout ← final carry.
- DONE→IDLE on the next edge, unconditionally.
- Output holding:
  - s and cout are updated only on the RUN→DONE edge.
  - They hold their value through IDLE and the next RUN until overwritten.
- Arithmetic is modulo 2^n. No overflow flag; signed overflow is the caller's concern.
- Boundary behaviour:
  - start while busy=1 (RUN or DONE): ignored, not queued.
  - start held high continuously: a new operation is accepted on the first edge in IDLE, giving back-to-back operations every n+2 cycles.
  - x, y and add_n may change freely after the accepting edge; they have no effect until the next accept.
  - rst asserted at any time, including mid-RUN: immediately force IDLE, clear all outputs, and discard the operation. No done pulse is produced for the aborted operation.

## Timing
- Reset values: busy=0, done=0, s=0, cout=0, state IDLE, all internal registers 0.
- Accepting edge is E0. busy=1 from E0.
- Bit-steps occur on edges E1..En.
- s, cout and done become valid after En.
- done is high for exactly the cycle between En and En+1.
- busy falls after En+1.
- Latency from the accepting edge to done is n edges. The request period is n+2 cycles.
- No combinational path from any input to any output. All outputs are registered.

## Test plan
- Reset then idle, n=8:
  - Hold rst for 3 cycles → busy=0, done=0, s=0x00, cout=0 during and after reset.
  - start=0 for 20 cycles → no change.
- Add, n=8:
  - x=0x0F, y=0x01, add_n=0 → done at E8, s=0x10, cout=0.
  - x=0xFF, y=0x01 → s=0x00, cout=1.
- Subtract, n=8:
  - x=0x05, y=0x07, add_n=1 → s=0xFE, cout=0.
  - x=0x07, y=0x05 → s=0x02, cout=1.
  - x=y=0x80 → s=0x00, cout=1.
- Protocol:
  - start pulsed again at E3 of an operation with different operands → ignored; first result is unchanged and only one done pulse occurs.
  - start held high → done pulses are spaced exactly n+2 cycles apart.
- Reset mid-operation:
  - Assert rst asynchronously (between edges) at E4 of 0x0F+0x01 → busy and s clear immediately, and no done pulse.
  - The next operation, 0x20+0x03, gives s=0x23.
- Exhaustive, n=4:
  - All 16×16 operand pairs for add_n=0 and add_n=1.
  - Each result is checked against the combinational adder_substractor_nbit with the same inputs.
  - Every s and cout match, and done fires once per request.

Source files
------------

// File: rtl/adder_substractor_serial_nbit.sv
// Bit-serial n-bit adder/subtractor: one request computes x + y or x - y LSB first
// over n cycles, then presents s/cout with a single-cycle done pulse.
module adder_substractor_serial_nbit #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         add_n,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] s,
    output logic         cout,
    output logic [1:0]   state_dbg
);

    localparam int CW = $clog2(n);
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    state_t        state;
    logic [n-1:0]  opa;
    logic [n-1:0]  opb;
    logic [n-1:0]  acc;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          sum_bit;
    logic          carry_nxt;

    // Handshake: start is a request that is taken only when busy is low (IDLE);
    // x, y and add_n are captured on that same edge, and any start seen while
    // busy is high is dropped rather than queued.

    always_comb begin
        sum_bit   = opa[0] ^ opb[0] ^ carry;
        carry_nxt = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtract as x + ~y + 1: invert y and seed the carry.
                        opa   <= x;
                        opb   <= y ^ {n{add_n}};
                        carry <= add_n;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    carry <= carry_nxt;
                    acc   <= {sum_bit, acc[n-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        s     <= {sum_bit, acc[n-1:1]};
                        cout  <= carry_nxt;
                        done  <= 1'b1;
                        state <= DONE_ST;
                    end
                end
                DONE_ST: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_adder_substractor_serial_nbit.sv
// Bench for the serial adder/subtractor: directed table, protocol corner cases,
// mid-operation reset, random n=8 operations and an exhaustive n=4 sweep.
module tb_adder_substractor_serial_nbit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] x8 = '0;
    logic [7:0] y8 = '0;
    logic       a8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] s8;
    logic [1:0] st8;

    logic       start4 = 1'b0;
    logic [3:0] x4 = '0;
    logic [3:0] y4 = '0;
    logic       a4 = 1'b0;
    logic       busy4, done4, cout4;
    logic [3:0] s4;
    logic [1:0] st4;

    int n_check = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int done_cnt8 = 0;
    int done_cnt4 = 0;
    int done_time8[$];

    logic [8:0] exp8_q[$];
    logic [4:0] exp4_q[$];

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       add_n;
        logic [7:0] s;
        logic       cout;
    } vec_t;

    vec_t vecs[6];

    adder_substractor_serial_nbit #(.n(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .x(x8), .y(y8), .add_n(a8),
        .busy(busy8), .done(done8), .s(s8), .cout(cout8), .state_dbg(st8)
    );

    adder_substractor_serial_nbit #(.n(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .x(x4), .y(y4), .add_n(a4),
        .busy(busy4), .done(done4), .s(s4), .cout(cout4), .state_dbg(st4)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_check++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    endtask

    // Reference model: plain modular arithmetic, returns {cout, s} as cout*2^w + s.
    function automatic int model(input int w, input int a, input int b, input logic sub);
        int m;
        int r;
        m = 1 << w;
        if (!sub) begin
            r = a + b;
            return ((r >= m) ? m : 0) + (r % m);
        end
        return ((a >= b) ? m : 0) + ((a - b + m) % m);
    endfunction

    // Scoreboards: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done8) begin
            done_cnt8++;
            done_time8.push_back(cyc);
            if (exp8_q.size() == 0) check("done8_without_request", 32'(done8), 32'd0);
            else check("result8", {23'd0, cout8, s8}, {23'd0, exp8_q.pop_front()});
        end
        if (done4) begin
            done_cnt4++;
            if (exp4_q.size() == 0) check("done4_without_request", 32'(done4), 32'd0);
            else check("result4", {27'd0, cout4, s4}, {27'd0, exp4_q.pop_front()});
        end
    end

    // Drivers
    task automatic launch8(input logic [7:0] xa, input logic [7:0] ya, input logic sub);
        @(negedge clk);
        x8 = xa; y8 = ya; a8 = sub; start8 = 1'b1;
        exp8_q.push_back(9'(model(8, int'(xa), int'(ya), sub)));
        @(negedge clk);
        start8 = 1'b0;
        check("busy8_after_accept", 32'(busy8), 32'd1);
    endtask

    // Waits for done8, scrambling inputs meanwhile; lat = negedges until done seen.
    task automatic wait_done8(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            x8 = 8'($urandom); y8 = 8'($urandom); a8 = 1'($urandom);
            if (done8) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) check("done8_timeout", 32'(done8), 32'd1);
    endtask

    task automatic op4(input int xa, input int ya, input logic sub);
        int k;
        @(negedge clk);
        x4 = 4'(xa); y4 = 4'(ya); a4 = sub; start4 = 1'b1;
        exp4_q.push_back(5'(model(4, xa, ya, sub)));
        @(negedge clk);
        start4 = 1'b0;
        for (k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done4) break;
        end
        if (k > 12) check("done4_timeout", 32'(done4), 32'd1);
    endtask

    initial begin
        int lat;
        int d0;
        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0};
        vecs[3] = '{8'h07, 8'h05, 1'b1, 8'h02, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h00, 1'b1};
        vecs[5] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};

        // Reset held 3 cycles, then 20 idle cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_busy", 32'(busy8), 32'd0);
            check("rst_done", 32'(done8), 32'd0);
            check("rst_s", 32'(s8), 32'd0);
            check("rst_cout", 32'(cout8), 32'd0);
            check("rst_state", 32'(st8), 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(busy8), 32'd0);
            check("idle_done", 32'(done8), 32'd0);
            check("idle_s", {23'd0, cout8, s8}, 32'd0);
        end

        // Directed table
        foreach (vecs[i]) begin
            launch8(vecs[i].x, vecs[i].y, vecs[i].add_n);
            wait_done8(lat);
            check("table_latency", 32'(lat), 32'd8);
            check("table_s", 32'(s8), 32'(vecs[i].s));
            check("table_cout", 32'(cout8), 32'(vecs[i].cout));
            check("table_busy_in_done", 32'(busy8), 32'd1);
            @(negedge clk);
            check("table_done_one_cycle", 32'(done8), 32'd0);
            check("table_busy_fall", 32'(busy8), 32'd0);
            check("table_s_hold", 32'(s8), 32'(vecs[i].s));
        end

        // start re-pulsed at E3 with other operands is ignored
        d0 = done_cnt8;
        launch8(8'h0F, 8'h01, 1'b0);
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1; x8 = 8'hAA; y8 = 8'h33; a8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(lat);
        check("repulse_latency", 32'(lat), 32'd5);
        check("repulse_s", 32'(s8), 32'h10);
        repeat (15) @(negedge clk);
        check("repulse_one_done", 32'(done_cnt8 - d0), 32'd1);

        // start held high: done pulses spaced n+2 cycles
        done_time8.delete();
        @(negedge clk);
        x8 = 8'h31; y8 = 8'h42; a8 = 1'b0; start8 = 1'b1;
        for (int i = 0; i < 3; i++) exp8_q.push_back(9'(model(8, 'h31, 'h42, 1'b0)));
        for (int k = 0; k < 60 && done_time8.size() < 3; k++) @(negedge clk);
        start8 = 1'b0;
        check("held_three_dones", 32'(done_time8.size()), 32'd3);
        if (done_time8.size() >= 3) begin
            check("held_spacing_1", 32'(done_time8[1] - done_time8[0]), 32'd10);
            check("held_spacing_2", 32'(done_time8[2] - done_time8[1]), 32'd10);
        end
        repeat (15) @(negedge clk);
        check("held_no_extra", 32'(exp8_q.size()), 32'd0);

        // Asynchronous reset at E4 of 0x0F+0x01
        d0 = done_cnt8;
        @(negedge clk);
        x8 = 8'h0F; y8 = 8'h01; a8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_s", {23'd0, cout8, s8}, 32'd0);
        check("abort_state", 32'(st8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (14) @(negedge clk);
        check("abort_no_done", 32'(done_cnt8 - d0), 32'd0);
        launch8(8'h20, 8'h03, 1'b0);
        wait_done8(lat);
        check("after_abort_latency", 32'(lat), 32'd8);
        check("after_abort_s", {23'd0, cout8, s8}, 32'h23);

        // Random n=8 operations, inputs scrambled while running
        for (int i = 0; i < 40; i++) begin
            launch8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            wait_done8(lat);
            check("rand_latency", 32'(lat), 32'd8);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Exhaustive n=4
        for (int sub = 0; sub < 2; sub++)
            for (int xa = 0; xa < 16; xa++)
                for (int ya = 0; ya < 16; ya++)
                    op4(xa, ya, 1'(sub));
        repeat (4) @(negedge clk);
        check("exh_done_count", 32'(done_cnt4), 32'd512);
        check("exh_queue_empty", 32'(exp4_q.size()), 32'd0);
        check("rand_queue_empty", 32'(exp8_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
